// File: rtl/multicycle_control.sv
// Main controller for the multicycle RV32I core: registered Moore FSM plus
// combinational ALU-control and immediate-select decoders.
module multicycle_control (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] imm_src_o,
  output logic [3:0] alu_control_o,
  output logic       illegal_op_o,
  output logic       instr_retired_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StJalr     = 4'd10,
    StBranch   = 4'd11,
    StLui      = 4'd12,
    StAuipc    = 4'd13
  } state_e;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSll  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  state_e state_q, state_d;

  logic [3:0] alu_r, alu_i, alu_b;
  logic       branch_ok;
  logic       pc_write, mem_write, ir_write, reg_write;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    imm_src_o = 3'b000;
    case (op_i)
      OpStore:        imm_src_o = 3'b001;
      OpBranch:       imm_src_o = 3'b010;
      OpJal:          imm_src_o = 3'b011;
      OpLui, OpAuipc: imm_src_o = 3'b100;
      default:        imm_src_o = 3'b000;
    endcase
  end

  always_comb begin
    alu_r = AluAdd;
    case (funct3_i)
      3'b000:  alu_r = funct7b5_i ? AluSub : AluAdd;
      3'b001:  alu_r = AluSll;
      3'b010:  alu_r = AluSlt;
      3'b011:  alu_r = AluSltu;
      3'b100:  alu_r = AluXor;
      3'b101:  alu_r = funct7b5_i ? AluSra : AluSrl;
      3'b110:  alu_r = AluOr;
      default: alu_r = AluAnd;
    endcase
    // Immediate forms have no SUB; bit 30 is part of the immediate there.
    alu_i = (funct3_i == 3'b000) ? AluAdd : alu_r;
    case (funct3_i[2:1])
      2'b10:   alu_b = AluSlt;
      2'b11:   alu_b = AluSltu;
      default: alu_b = AluSub;
    endcase
    branch_ok = (funct3_i[2:1] != 2'b01);
  end

  always_comb begin
    state_d         = StFetch;
    pc_write        = 1'b0;
    adr_src_o       = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    result_src_o    = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_control_o   = AluAdd;
    illegal_op_o    = 1'b0;
    instr_retired_o = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write     = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_write     = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecuteR;
          OpI:             state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpBranch:        state_d = branch_ok ? StBranch : StFetch;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StFetch;
        endcase
        illegal_op_o = (state_d == StFetch);
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = op_i[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src_o = 1'b1;
        state_d   = StMemWb;
      end
      StMemWb: begin
        result_src_o    = 2'b01;
        reg_write       = 1'b1;
        instr_retired_o = 1'b1;
      end
      StMemWrite: begin
        adr_src_o       = 1'b1;
        mem_write       = 1'b1;
        instr_retired_o = 1'b1;
      end
      StExecuteR: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = alu_r;
        state_d       = StAluWb;
      end
      StExecuteI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_i;
        state_d       = StAluWb;
      end
      StAluWb: begin
        reg_write       = 1'b1;
        instr_retired_o = 1'b1;
      end
      StJal: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write    = 1'b1;
        state_d     = StAluWb;
      end
      StJalr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = StJal;
      end
      StBranch: begin
        alu_src_a_o     = 2'b10;
        alu_control_o   = alu_b;
        pc_write        = zero_i ^ funct3_i[0] ^ funct3_i[2];
        instr_retired_o = 1'b1;
      end
      StLui: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
        state_d     = StAluWb;
      end
      StAuipc: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        state_d     = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset is asynchronous, so gate enables directly rather than wait for the state.
  assign pc_write_o  = pc_write & ~reset_i;
  assign mem_write_o = mem_write & ~reset_i;
  assign ir_write_o  = ir_write & ~reset_i;
  assign reg_write_o = reg_write & ~reset_i;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: every cycle's full control bundle is
// compared against an instruction-level reference model.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm_src;
    logic [3:0] alu;
    logic       illegal;
    logic       retired;
  } ctl_t;

  localparam int KIll = 0, KLw = 1, KSw = 2, KR = 3, KI = 4, KJal = 5, KJalr = 6;
  localparam int KBr = 7, KLui = 8, KAuipc = 9;

  logic       clk, reset, zero, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, instr_retired;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  ctl_t       got;

  int n_vec = 0;
  int n_err = 0;

  multicycle_control dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .op_i           (op),
    .funct3_i       (funct3),
    .funct7b5_i     (funct7b5),
    .zero_i         (zero),
    .pc_write_o     (pc_write),
    .adr_src_o      (adr_src),
    .mem_write_o    (mem_write),
    .ir_write_o     (ir_write),
    .reg_write_o    (reg_write),
    .result_src_o   (result_src),
    .alu_src_a_o    (alu_src_a),
    .alu_src_b_o    (alu_src_b),
    .imm_src_o      (imm_src),
    .alu_control_o  (alu_control),
    .illegal_op_o   (illegal_op),
    .instr_retired_o(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, illegal_op, instr_retired};

  task automatic check_ctl(input string tag, input ctl_t obs, input ctl_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b (op=%b f3=%b f7b5=%b zero=%b)",
               tag, obs, exp, op, funct3, funct7b5, zero);
    end
  endtask

  function automatic int ref_class(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011: return KLw;
      7'b0100011: return KSw;
      7'b0110011: return KR;
      7'b0010011: return KI;
      7'b1101111: return KJal;
      7'b1100111: return KJalr;
      7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? KIll : KBr;
      7'b0110111: return KLui;
      7'b0010111: return KAuipc;
      default:    return KIll;
    endcase
  endfunction

  function automatic int ref_len(input int k);
    case (k)
      KIll:      return 2;
      KBr:       return 3;
      KLw, KJalr: return 5;
      default:   return 4;
    endcase
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  // Mnemonic -> ALU code: add sub and or xor slt sll srl sra sltu = 0..9.
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic ctl_t ref_ctl(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int cyc);
    ctl_t c;
    int   k;
    int   n;
    c = '0;
    k = ref_class(o, f3);
    n = ref_len(k);
    c.imm_src = ref_imm(o);
    if (cyc == 0) begin
      c.pc_write = 1; c.ir_write = 1; c.src_b = 2; c.result_src = 2;
    end else if (cyc == 1) begin
      c.src_a = 1; c.src_b = 1; c.illegal = (k == KIll);
    end else if (cyc == n - 1 && k != KSw && k != KLw && k != KBr) begin
      c.reg_write = 1;  // ALU writeback
    end else begin
      case (k)
        KLw, KSw: begin
          if (cyc == 2) begin
            c.src_a = 2; c.src_b = 1;
          end else if (k == KSw) begin
            c.adr_src = 1; c.mem_write = 1;
          end else if (cyc == 3) begin
            c.adr_src = 1;
          end else begin
            c.result_src = 1; c.reg_write = 1;
          end
        end
        KR:    begin c.src_a = 2; c.alu = ref_alu(f3, f7, 1'b1); end
        KI:    begin c.src_a = 2; c.src_b = 1; c.alu = ref_alu(f3, f7, 1'b0); end
        KJal:  begin c.src_a = 1; c.src_b = 2; c.pc_write = 1; end
        KJalr: begin
          if (cyc == 2) begin
            c.src_a = 2; c.src_b = 1;
          end else begin
            c.src_a = 1; c.src_b = 2; c.pc_write = 1;
          end
        end
        KBr: begin
          c.src_a = 2;
          c.alu = (f3[2:1] == 2'b11) ? 4'd9 : (f3[2] ? 4'd5 : 4'd1);
          c.pc_write = (f3[0] ^ f3[2]) ? !z : z;
        end
        KLui:   begin c.src_a = 3; c.src_b = 1; end
        default: begin c.src_a = 1; c.src_b = 1; end
      endcase
    end
    c.retired = (k != KIll) && (cyc == n - 1);
    return c;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
  // zmode 0/1 forces zero, anything else randomizes it every cycle.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode);
    int n;
    n = ref_len(ref_class(o, f3));
    op = o; funct3 = f3; funct7b5 = f7;
    for (int cyc = 0; cyc < n; cyc++) begin
      zero = (zmode == 0 || zmode == 1) ? zmode[0] : 1'($urandom);
      @(negedge clk);
      check_ctl($sformatf("%s.c%0d", tag, cyc), got, ref_ctl(o, f3, f7, zero, cyc));
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

  initial begin
    ctl_t       exp_rst;
    logic [6:0] rop;
    reset = 1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_rst = ref_ctl(op, funct3, funct7b5, zero, 0);
    exp_rst.pc_write = 0;
    exp_rst.ir_write = 0;
    check_ctl("reset_hold", got, exp_rst);
    @(posedge clk);
    #1 reset = 0;

    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 2);

    // Abort a load in MEMREAD with an asynchronous reset.
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check_ctl($sformatf("lw_abort.c%0d", cyc), got, ref_ctl(op, funct3, funct7b5, zero, cyc));
      if (cyc < 3) @(posedge clk);
    end
    #1 reset = 1;
    #1 check_ctl("reset_async", got, exp_rst);
    @(posedge clk);
    #1 reset = 0;
    run_instr("after_reset", 7'b0000011, 3'b010, 1'b0, 2);

    run_instr("sra", 7'b0110011, 3'b101, 1'b1, 2);
    run_instr("addi_b30", 7'b0010011, 3'b000, 1'b1, 2);
    run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 0);
    run_instr("bge_z0", 7'b1100011, 3'b101, 1'b0, 0);
    run_instr("bltu_z0", 7'b1100011, 3'b110, 1'b0, 0);
    run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1);
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0, 2);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 2);
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 2);
    run_instr("lui", 7'b0110111, 3'b000, 1'b0, 2);
    run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 2);
    run_instr("ill_op", 7'b1111111, 3'b000, 1'b0, 2);
    run_instr("ill_br", 7'b1100011, 3'b010, 1'b0, 2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) rop = 7'($urandom);
      else rop = legal_ops[$urandom_range(8)];
      run_instr($sformatf("rnd%0d", i), rop, 3'($urandom), 1'($urandom), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main controller for the multicycle RV32I core: a registered Moore FSM plus combinational ALU and immediate decoders. It sequences fetch, decode, execute, memory and writeback, and drives every datapath mux and write enable. It sits directly upstream of the ALU: it produces `alu_control` and consumes the ALU's `zero` flag for branch resolution.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; state := FETCH.
- `op` in 7: instr[6:0], from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = Result.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: IR/OldPC enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = RD1 (A reg), 11 = 0.
- `alu_src_b` out 2: 00 = RD2 (WriteData reg), 01 = ImmExt, 10 = 4.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 J, 100 U; decoded from `op` only.
- `alu_control` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001.
- `illegal_op` out 1: 1-cycle pulse in DECODE for an unsupported op, or for branch funct3 010/011.
- `instr_retired` out 1: 1-cycle pulse in the last state of each instruction.

## Operation
- State register is 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, JAL 9, JALR 10, BRANCH 11, LUI 12, AUIPC 13. Codes 14 and 15 go to FETCH with all enables 0.
- Unlisted outputs in each state are 0.

State outputs and next state:
- **FETCH:** adr_src 0, ir_write 1, src_a 00, src_b 10, ADD, result_src 10, pc_write 1. Next: DECODE.
- **DECODE:** src_a 01, src_b 01, ADD (speculative branch/JAL target into ALUOut). Next state by `op`:
  - 0000011, 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else (including illegal branch funct3) → FETCH with `illegal_op`=1.
- **MEMADR:** src_a 10, src_b 01, ADD. Next: MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD:** result_src 00, adr_src 1. Next: MEMWB.
- **MEMWB:** result_src 01, reg_write 1, retired. Next: FETCH.
- **MEMWRITE:** result_src 00, adr_src 1, mem_write 1, retired. Next: FETCH.
- **EXECUTER:** src_a 10, src_b 00, R-decode. Next: ALUWB.
- **EXECUTEI:** src_a 10, src_b 01, I-decode. Next: ALUWB.
- **ALUWB:** result_src 00, reg_write 1, retired. Next: FETCH.
- **JAL:** src_a 01, src_b 10, ADD, result_src 00, pc_write 1. PC := ALUOut (target) while OldPC+4 is computed. Next: ALUWB.
- **JALR:** src_a 10, src_b 01, ADD (rs1+imm into ALUOut). Next: JAL. Bit-0 clearing is a datapath responsibility.
- **BRANCH:** src_a 10, src_b 00, result_src 00, pc_write = taken, retired. Next: FETCH.
  - ALU op: funct3 00x → SUB, 10x → SLT, 11x → SLTU.
  - taken = `zero` ^ funct3[0] ^ funct3[2].
- **LUI:** src_a 11, src_b 01, ADD. Next: ALUWB.
- **AUIPC:** src_a 01, src_b 01, ADD. Next: ALUWB.

ALU decode:
- **R-decode** by funct3:
  - 000: SUB if funct7b5, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5, else SRL
  - 110: OR
  - 111: AND
- **I-decode:** same as R-decode, except 000 is always ADD.

## Timing
- Outputs are combinational from the registered state, plus `op`/`funct3`/`funct7b5`/`zero`. The IR is stable from DECODE onward.
- Cycles per instruction:
  - branch: 3
  - sw, R, I, LUI, AUIPC, JAL: 4
  - lw, JALR: 5
  - illegal: 2
- While `reset`=1, all write enables are forced to 0. Mux outputs show FETCH values.
- Reset assertion mid-instruction takes effect immediately and asynchronously, aborting the instruction. The first FETCH executes on the first rising edge after deassertion.
- `zero` is sampled only in BRANCH. `pc_write` in BRANCH follows `zero` within the same cycle.

## Test plan
- Reset asserted during MEMREAD → state FETCH immediately, all write enables 0. After release: ir_write=1 and pc_write=1 on the first cycle.
- lw (op 0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 only in cycle 5. instr_retired pulses once.
- R-type: funct3=101, funct7b5=1 → alu_control 1000 in EXECUTER. I-type: funct3=000, funct7b5=1 → 0000 (ADD, not SUB).
- Branches, with `zero` forced:
  - bne, zero=0 → pc_write=1.
  - bge (funct3 101), zero=0 → pc_write=0.
  - bltu, zero=0 → alu_control 1001, pc_write=1.
  - Each branch takes 3 cycles.
- jalr → FETCH, DECODE, JALR, JAL, ALUWB. pc_write=1 in FETCH and JAL only. imm_src=000.
- op 1111111, and branch funct3=010 → illegal_op=1 in DECODE, next FETCH, no reg/mem/pc write in DECODE.
